// File: rtl/gray_ptr_counter.sv
// Up/down binary pointer counter with a zero-skew registered Gray image,
// plus an independent registered Gray-to-binary decoder for the far-side pointer.
module gray_ptr_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] dec_bin_out
);

  localparam logic [WIDTH-1:0] RST_BIN = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_BIN = '1;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] r_dec;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_dec;

  always_comb begin
    w_next      = r_bin;
    w_wrap_next = 1'b0;
    if (rst) begin
      w_next = RST_BIN;
    end else if (load) begin
      w_next = load_val;
    end else if (inc && !dec) begin
      w_next      = r_bin + 1'b1;
      w_wrap_next = (r_bin == MAX_BIN);
    end else if (dec && !inc) begin
      w_next      = r_bin - 1'b1;
      w_wrap_next = (r_bin == '0);
    end
  end

  assign w_gray_next = bin2gray(w_next);

  // Each decoded bit is the XOR of all Gray bits at or above it; written as a
  // reduction per bit so there is no ripple chain through a single vector.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign w_dec[gi] = ^(gray_in >> gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= RST_BIN;
      r_gray <= bin2gray(RST_BIN);
      r_wrap <= 1'b0;
      r_dec  <= '0;
    end else begin
      r_bin  <= w_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
      r_dec  <= w_dec;
    end
  end

  assign bin_out     = r_bin;
  assign gray_out    = r_gray;
  assign gray_next   = w_gray_next;
  assign wrap        = r_wrap;
  assign dec_bin_out = r_dec;

endmodule
